// File: rtl/imem_loader.sv
// Instruction encoder/loader: turns decoded op requests into RV64I words and
// writes them to consecutive instruction-memory word addresses.
module imem_loader #(
  parameter int unsigned ADDR_W    = 5,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [4:0]        req_rd,
  input  logic [4:0]        req_rs1,
  input  logic [4:0]        req_rs2,
  input  logic [11:0]       req_imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   count
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_LD  = 3'd4;
  localparam logic [2:0] OP_SD  = 3'd5;
  localparam logic [2:0] OP_BEQ = 3'd6;
  localparam logic [2:0] OP_END = 3'd7;

  localparam logic [6:0] OPC_RTYPE = 7'b0110011;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_BRNCH = 7'b1100011;

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
  // Count value meaning every word of memory has been written once.
  localparam logic [CNT_W-1:0]  CAP  = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic {
    IDLE = 1'b0,
    LOAD = 1'b1
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic [31:0]       enc;
  logic              accept;
  logic              full;

  assign req_ready = (state == LOAD) && !start;
  assign busy      = (state == LOAD);
  assign accept    = req_valid && req_ready;
  assign full      = (count == CAP);

  // Encode the current request into its 32-bit instruction word.
  always_comb begin
    enc = 32'h0;
    unique case (req_op)
      OP_ADD: enc = {7'b0000000, req_rs2, req_rs1, 3'b000, req_rd, OPC_RTYPE};
      OP_SUB: enc = {7'b0100000, req_rs2, req_rs1, 3'b000, req_rd, OPC_RTYPE};
      OP_AND: enc = {7'b0000000, req_rs2, req_rs1, 3'b111, req_rd, OPC_RTYPE};
      OP_OR:  enc = {7'b0000000, req_rs2, req_rs1, 3'b110, req_rd, OPC_RTYPE};
      OP_LD:  enc = {req_imm, req_rs1, 3'b011, req_rd, OPC_LOAD};
      OP_SD:  enc = {req_imm[11:5], req_rs2, req_rs1, 3'b011, req_imm[4:0], OPC_STORE};
      // req_imm holds offset bits [12:1]; bit 0 is always zero.
      OP_BEQ: enc = {req_imm[11], req_imm[9:4], req_rs2, req_rs1, 3'b000,
                     req_imm[3:0], req_imm[10], OPC_BRNCH};
      OP_END: enc = 32'h0;
      default: enc = 32'h0;
    endcase
  end

  // Load sequencer: state, write port and bookkeeping all registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ptr        <= BASE;
      count      <= '0;
      error      <= 1'b0;
      done       <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
    end else begin
      imem_we <= 1'b0;
      done    <= 1'b0;
      if (start) begin
        state <= LOAD;
        ptr   <= BASE;
        count <= '0;
        error <= 1'b0;
      end else if (accept) begin
        if (req_op == OP_END) begin
          state <= IDLE;
          done  <= 1'b1;
        end else if (!full) begin
          imem_we    <= 1'b1;
          imem_addr  <= ptr;
          imem_wdata <= enc;
          ptr        <= ptr + ADDR_W'(1);
          count      <= count + CNT_W'(1);
        end else begin
          error <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: three parameterisations driven in lock-step and
// compared against a behavioural model of the load protocol.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        req_valid = 1'b0;
  logic [2:0]  req_op = 3'd0;
  logic [4:0]  req_rd = 5'd0;
  logic [4:0]  req_rs1 = 5'd0;
  logic [4:0]  req_rs2 = 5'd0;
  logic [11:0] req_imm = 12'd0;

  logic        rdy0, we0, busy0, done0, err0;
  logic [4:0]  addr0;
  logic [31:0] wd0;
  logic [5:0]  cnt0;
  logic        rdy1, we1, busy1, done1, err1;
  logic [1:0]  addr1;
  logic [31:0] wd1;
  logic [2:0]  cnt1;
  logic        rdy2, we2, busy2, done2, err2;
  logic [4:0]  addr2;
  logic [31:0] wd2;
  logic [5:0]  cnt2;

  imem_loader #(.ADDR_W(5), .BASE_ADDR(0)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start), .req_valid(req_valid), .req_ready(rdy0),
    .req_op(req_op), .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_imm(req_imm),
    .imem_we(we0), .imem_addr(addr0), .imem_wdata(wd0), .busy(busy0), .done(done0),
    .error(err0), .count(cnt0));

  imem_loader #(.ADDR_W(2), .BASE_ADDR(0)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start), .req_valid(req_valid), .req_ready(rdy1),
    .req_op(req_op), .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_imm(req_imm),
    .imem_we(we1), .imem_addr(addr1), .imem_wdata(wd1), .busy(busy1), .done(done1),
    .error(err1), .count(cnt1));

  imem_loader #(.ADDR_W(5), .BASE_ADDR(30)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start), .req_valid(req_valid), .req_ready(rdy2),
    .req_op(req_op), .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_imm(req_imm),
    .imem_we(we2), .imem_addr(addr2), .imem_wdata(wd2), .busy(busy2), .done(done2),
    .error(err2), .count(cnt2));

  always #5 clk = ~clk;

  // Observed outputs gathered per instance, zero-extended to common widths.
  logic        rdy_a[3], we_a[3], busy_a[3], done_a[3], err_a[3];
  logic [4:0]  addr_a[3];
  logic [31:0] wd_a[3];
  logic [5:0]  cnt_a[3];

  always_comb begin
    rdy_a[0] = rdy0;  we_a[0] = we0;  busy_a[0] = busy0;  done_a[0] = done0;  err_a[0] = err0;
    addr_a[0] = addr0; wd_a[0] = wd0; cnt_a[0] = cnt0;
    rdy_a[1] = rdy1;  we_a[1] = we1;  busy_a[1] = busy1;  done_a[1] = done1;  err_a[1] = err1;
    addr_a[1] = {3'b000, addr1}; wd_a[1] = wd1; cnt_a[1] = {3'b000, cnt1};
    rdy_a[2] = rdy2;  we_a[2] = we2;  busy_a[2] = busy2;  done_a[2] = done2;  err_a[2] = err2;
    addr_a[2] = addr2; wd_a[2] = wd2; cnt_a[2] = cnt2;
  end

  int unsigned base_a[3] = '{0, 0, 30};
  int unsigned cap_a[3]  = '{32, 4, 32};

  // Behavioural model state.
  bit          m_load[3];
  int unsigned m_ptr[3], m_cnt[3], m_addr[3];
  bit          m_err[3], m_we[3], m_done[3];
  logic [31:0] m_wdata[3];

  int n_checks = 0;
  int n_fail = 0;

  // Reference encoding from the RISC-V field layout; BEQ uses the byte offset.
  function automatic logic [31:0] ref_enc(int unsigned op, int unsigned rd, int unsigned rs1,
                                          int unsigned rs2, int unsigned imm);
    int unsigned w, f7, f3, off;
    f7 = 0; f3 = 0; w = 0;
    case (op)
      0: begin f7 = 0;  f3 = 0; end
      1: begin f7 = 32; f3 = 0; end
      2: begin f7 = 0;  f3 = 7; end
      3: begin f7 = 0;  f3 = 6; end
      default: ;
    endcase
    if (op <= 3)
      w = (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 51;
    else if (op == 4)
      w = (imm << 20) | (rs1 << 15) | (3 << 12) | (rd << 7) | 3;
    else if (op == 5)
      w = ((imm >> 5) << 25) | (rs2 << 20) | (rs1 << 15) | (3 << 12) | ((imm & 31) << 7) | 35;
    else if (op == 6) begin
      off = imm * 2;
      w = (((off >> 12) & 1) << 31) | (((off >> 5) & 63) << 25) | (rs2 << 20) | (rs1 << 15)
        | (((off >> 1) & 15) << 8) | (((off >> 11) & 1) << 7) | 99;
    end
    return w;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_load[i] = 0; m_ptr[i] = base_a[i]; m_cnt[i] = 0; m_err[i] = 0;
      m_we[i] = 0; m_done[i] = 0; m_addr[i] = 0; m_wdata[i] = 32'h0;
    end
  endtask

  // Apply the current inputs at the next rising edge, advancing the model alongside.
  task automatic step();
    for (int i = 0; i < 3; i++) begin
      m_we[i] = 0; m_done[i] = 0;
      if (start) begin
        m_load[i] = 1; m_ptr[i] = base_a[i]; m_cnt[i] = 0; m_err[i] = 0;
      end else if (m_load[i] && req_valid) begin
        if (req_op == 3'd7) begin
          m_load[i] = 0; m_done[i] = 1;
        end else if (m_cnt[i] < cap_a[i]) begin
          m_we[i] = 1; m_addr[i] = m_ptr[i];
          m_wdata[i] = ref_enc(req_op, req_rd, req_rs1, req_rs2, req_imm);
          m_ptr[i] = (m_ptr[i] + 1) % cap_a[i];
          m_cnt[i]++;
        end else begin
          m_err[i] = 1;
        end
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic set_req(input bit v, input logic [2:0] op, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [11:0] imm);
    req_valid = v; req_op = op; req_rd = rd; req_rs1 = rs1; req_rs2 = rs2; req_imm = imm;
  endtask

  task automatic test_reset();
    n_checks++;
    if ({rdy0, we0, busy0, done0, err0} !== 5'b0) begin
      n_fail++; $display("FAIL reset_flags got %b expected 00000", {rdy0, we0, busy0, done0, err0});
    end
    n_checks++;
    if ({addr0, wd0, cnt0} !== 43'h0) begin
      n_fail++; $display("FAIL reset_regs got addr=%h data=%h count=%0d expected zeros", addr0, wd0, cnt0);
    end
  endtask

  task automatic test_add_end();
    start = 1; step(); start = 0;
    set_req(1, 3'd0, 5'd3, 5'd1, 5'd2, 12'h0); step();
    n_checks++;
    if (we0 !== 1'b1 || addr0 !== 5'd0 || wd0 !== 32'h002081B3) begin
      n_fail++; $display("FAIL add_write got we=%b addr=%0d data=%h expected 1/0/002081b3", we0, addr0, wd0);
    end
    set_req(1, 3'd7, 5'd0, 5'd0, 5'd0, 12'h0); step();
    n_checks++;
    if (done0 !== 1'b1 || busy0 !== 1'b0 || cnt0 !== 6'd1 || we0 !== 1'b0) begin
      n_fail++; $display("FAIL end_done got done=%b busy=%b count=%0d we=%b expected 1/0/1/0", done0, busy0, cnt0, we0);
    end
    set_req(0, 3'd0, 5'd0, 5'd0, 5'd0, 12'h0); step();
    n_checks++;
    if (done0 !== 1'b0) begin
      n_fail++; $display("FAIL done_pulse got %b expected 0", done0);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_d[3] = '{32'h407302B3, 32'h00813203, 32'h00513823};
    start = 1; step(); start = 0;
    for (int k = 0; k < 3; k++) begin
      case (k)
        0: set_req(1, 3'd1, 5'd5, 5'd6, 5'd7, 12'd0);
        1: set_req(1, 3'd4, 5'd4, 5'd2, 5'd0, 12'd8);
        default: set_req(1, 3'd5, 5'd0, 5'd2, 5'd5, 12'd16);
      endcase
      step();
      n_checks++;
      if (we0 !== 1'b1 || addr0 !== 5'(k) || wd0 !== exp_d[k]) begin
        n_fail++; $display("FAIL b2b_%0d got we=%b addr=%0d data=%h expected 1/%0d/%h", k, we0, addr0, wd0, k, exp_d[k]);
      end
    end
    set_req(1, 3'd7, 5'd0, 5'd0, 5'd0, 12'h0); step();
    n_checks++;
    if (we0 !== 1'b0 || cnt0 !== 6'd3 || addr0 !== 5'd2) begin
      n_fail++; $display("FAIL b2b_hold got we=%b count=%0d addr=%0d expected 0/3/2", we0, cnt0, addr0);
    end
    set_req(0, 3'd0, 5'd0, 5'd0, 5'd0, 12'h0);
  endtask

  task automatic test_beq();
    start = 1; step(); start = 0;
    set_req(1, 3'd6, 5'd9, 5'd1, 5'd2, 12'hFFC); step();
    n_checks++;
    if (we0 !== 1'b1 || wd0 !== 32'hFE208CE3) begin
      n_fail++; $display("FAIL beq_enc got we=%b data=%h expected 1/fe208ce3", we0, wd0);
    end
    set_req(1, 3'd7, 5'd0, 5'd0, 5'd0, 12'h0); step();
    set_req(0, 3'd0, 5'd0, 5'd0, 5'd0, 12'h0);
  endtask

  task automatic test_overflow_wrap();
    int unsigned exp_u2[3] = '{30, 31, 0};
    start = 1; step(); start = 0;
    for (int k = 0; k < 5; k++) begin
      set_req(1, 3'd0, 5'(k + 1), 5'd1, 5'd2, 12'h0); step();
      if (k < 4) begin
        n_checks++;
        if (we1 !== 1'b1 || addr1 !== 2'(k)) begin
          n_fail++; $display("FAIL ovf_write_%0d got we=%b addr=%0d expected 1/%0d", k, we1, addr1, k);
        end
      end else begin
        n_checks++;
        if (we1 !== 1'b0 || err1 !== 1'b1 || cnt1 !== 3'd4) begin
          n_fail++; $display("FAIL ovf_drop got we=%b err=%b count=%0d expected 0/1/4", we1, err1, cnt1);
        end
      end
      if (k < 3) begin
        n_checks++;
        if (we2 !== 1'b1 || 32'(addr2) !== exp_u2[k]) begin
          n_fail++; $display("FAIL wrap_%0d got we=%b addr=%0d expected 1/%0d", k, we2, addr2, exp_u2[k]);
        end
      end
    end
    set_req(0, 3'd0, 5'd0, 5'd0, 5'd0, 12'h0);
    start = 1; step(); start = 0;
    n_checks++;
    if (err1 !== 1'b0 || cnt1 !== 3'd0) begin
      n_fail++; $display("FAIL ovf_clear got err=%b count=%0d expected 0/0", err1, cnt1);
    end
    set_req(1, 3'd7, 5'd0, 5'd0, 5'd0, 12'h0); step();
    set_req(0, 3'd0, 5'd0, 5'd0, 5'd0, 12'h0);
  endtask

  task automatic test_start_midload();
    start = 1; step(); start = 0;
    set_req(1, 3'd2, 5'd1, 5'd2, 5'd3, 12'h0); step();
    set_req(1, 3'd3, 5'd4, 5'd5, 5'd6, 12'h0); step();
    start = 1; #1;
    n_checks++;
    if (rdy0 !== 1'b0) begin
      n_fail++; $display("FAIL restart_ready got %b expected 0", rdy0);
    end
    step(); start = 0;
    n_checks++;
    if (we0 !== 1'b0 || cnt0 !== 6'd0 || busy0 !== 1'b1) begin
      n_fail++; $display("FAIL restart_noaccept got we=%b count=%0d busy=%b expected 0/0/1", we0, cnt0, busy0);
    end
    step();
    n_checks++;
    if (we0 !== 1'b1 || addr0 !== 5'd0 || addr2 !== 5'd30) begin
      n_fail++; $display("FAIL restart_base got we=%b addr0=%0d addr2=%0d expected 1/0/30", we0, addr0, addr2);
    end
  endtask

  task automatic test_reset_midload();
    set_req(1, 3'd0, 5'd1, 5'd1, 5'd1, 12'h0); step();
    #2 rst_n = 0; #1;
    n_checks++;
    if (we0 !== 1'b0 || busy0 !== 1'b0 || cnt0 !== 6'd0) begin
      n_fail++; $display("FAIL async_reset got we=%b busy=%b count=%0d expected 0/0/0", we0, busy0, cnt0);
    end
    model_reset();
    set_req(0, 3'd0, 5'd0, 5'd0, 5'd0, 12'h0);
    @(posedge clk); #1 rst_n = 1;
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      start = ($urandom_range(0, 19) == 0);
      req_valid = ($urandom_range(0, 3) != 0);
      req_op = ($urandom_range(0, 11) == 0) ? 3'd7 : 3'($urandom_range(0, 6));
      req_rd = 5'($urandom); req_rs1 = 5'($urandom); req_rs2 = 5'($urandom);
      req_imm = 12'($urandom);
      #1;
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (rdy_a[i] !== (m_load[i] && !start)) begin
          n_fail++; $display("FAIL rnd_ready c%0d i%0d got %b expected %b", c, i, rdy_a[i], m_load[i] && !start);
        end
      end
      step();
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (we_a[i] !== m_we[i] || done_a[i] !== m_done[i] || busy_a[i] !== m_load[i]
            || err_a[i] !== m_err[i] || 32'(cnt_a[i]) !== m_cnt[i]) begin
          n_fail++;
          $display("FAIL rnd_ctrl c%0d i%0d got we=%b done=%b busy=%b err=%b cnt=%0d expected %b/%b/%b/%b/%0d",
                   c, i, we_a[i], done_a[i], busy_a[i], err_a[i], cnt_a[i],
                   m_we[i], m_done[i], m_load[i], m_err[i], m_cnt[i]);
        end
        n_checks++;
        if (32'(addr_a[i]) !== m_addr[i] || wd_a[i] !== m_wdata[i]) begin
          n_fail++; $display("FAIL rnd_data c%0d i%0d got addr=%0d data=%h expected %0d/%h",
                             c, i, addr_a[i], wd_a[i], m_addr[i], m_wdata[i]);
        end
      end
    end
    start = 0;
    set_req(0, 3'd0, 5'd0, 5'd0, 5'd0, 12'h0);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    test_reset();
    test_add_end();
    test_back_to_back();
    test_beq();
    test_overflow_wrap();
    test_start_midload();
    test_reset_midload();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
